btn_conditioner: RTL and testbench

Push-button conditioning stage that sits directly upstream of the 60-counter top level. It turns a raw, bouncing, asynchronous button into clean control signals for the counter:
- a debounced level, used as the count-direction input;
- a one-cycle press pulse;
- a toggle bit;
- auto-repeat pulses while the button is held.

All timing runs on the 1 kHz sample strobe that the top level already derives from its free-running prescaler.

---
 rtl/btn_pkg.sv | 14 +
 rtl/sync2.sv | 21 ++
 rtl/btn_conditioner.sv | 130 +++++++++++++
 tb/tb_btn_conditioner.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types for the push-button conditioning path.
package btn_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    HELD        = 3'd2,
    REPEAT      = 3'd3,
    DEB_RELEASE = 3'd4
  } btn_state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module sync2 (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Button debounce / press / toggle / auto-repeat controller, timed by a 1 kHz TICK.
// state       | meaning
// IDLE        | button released and stable
// DEB_PRESS   | s high, counting stable TICKs before accepting the press
// HELD        | press accepted, counting towards the first repeat
// REPEAT      | auto-repeat running every REPEAT_RATE TICKs
// DEB_RELEASE | s low, counting stable TICKs before accepting the release
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 16,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic TICK,
  input  logic BTN_IN,
  output logic LEVEL,
  output logic PRESS_P,
  output logic REP_P,
  output logic TOGGLE
);

  localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] DLY_LIM  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_LIM = CNT_W'(REPEAT_RATE);

  logic             s;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  sync2 u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (BTN_IN),
    .q     (s)
  );

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      LEVEL   <= 1'b0;
      PRESS_P <= 1'b0;
      REP_P   <= 1'b0;
      TOGGLE  <= 1'b0;
    end else begin
      PRESS_P <= 1'b0;
      REP_P   <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= DEB_PRESS;
            cnt   <= '0;
          end
        end
        // a low sample aborts even when it coincides with a TICK
        DEB_PRESS: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (TICK) begin
            if (cnt_inc == DEB_LIM) begin
              state   <= HELD;
              cnt     <= '0;
              LEVEL   <= 1'b1;
              PRESS_P <= 1'b1;
              TOGGLE  <= ~TOGGLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        // with repeat disabled the counter parks at REPEAT_DELAY
        HELD: begin
          if (!s) begin
            state <= DEB_RELEASE;
            cnt   <= '0;
          end else if (TICK && (cnt != DLY_LIM)) begin
            if (REPEAT_EN && (cnt_inc == DLY_LIM)) begin
              state <= REPEAT;
              cnt   <= '0;
              REP_P <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        REPEAT: begin
          if (!s) begin
            state <= DEB_RELEASE;
            cnt   <= '0;
          end else if (TICK) begin
            if (cnt_inc == RATE_LIM) begin
              cnt   <= '0;
              REP_P <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        // a re-rise returns to HELD without a new press; repeat delay restarts
        DEB_RELEASE: begin
          if (s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (TICK) begin
            if (cnt_inc == DEB_LIM) begin
              state <= IDLE;
              cnt   <= '0;
              LEVEL <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench: expected pulses (kind, TICK index) are queued as stimulus is driven.
module tb_btn_conditioner;

  localparam int K_PRESS = 1;
  localparam int K_REP   = 2;

  typedef struct {
    int kind;
    int tick;
  } ev_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic TICK = 1'b0;
  logic BTN_IN = 1'b0;
  logic level, press_p, rep_p, toggle;
  logic level_nr, press_nr, rep_nr, toggle_nr;

  ev_t  exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   tick_idx = 0;
  logic last_tick = 1'b0;
  int   cyc_n = 0;
  logic prev_pulse = 1'b0;
  int   nr_press_cnt = 0;
  int   nr_rep_cnt = 0;

  btn_conditioner #(
    .DEBOUNCE_TICKS (4),
    .REPEAT_DELAY   (8),
    .REPEAT_RATE    (3),
    .REPEAT_EN      (1'b1)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .TICK    (TICK),
    .BTN_IN  (BTN_IN),
    .LEVEL   (level),
    .PRESS_P (press_p),
    .REP_P   (rep_p),
    .TOGGLE  (toggle)
  );

  btn_conditioner #(
    .DEBOUNCE_TICKS (4),
    .REPEAT_DELAY   (8),
    .REPEAT_RATE    (3),
    .REPEAT_EN      (1'b0)
  ) dut_nr (
    .CLK     (CLK),
    .RESET   (RESET),
    .TICK    (TICK),
    .BTN_IN  (BTN_IN),
    .LEVEL   (level_nr),
    .PRESS_P (press_nr),
    .REP_P   (rep_nr),
    .TOGGLE  (toggle_nr)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    cyc_n++;
    TICK = (cyc_n % 10 == 0);
  end

  always @(posedge CLK) begin
    last_tick <= TICK;
    if (TICK) tick_idx <= tick_idx + 1;
  end

  task automatic check(input string tag, input int got, input int exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp_v, $time);
    end
  endtask

  task automatic push(input int kind, input int tick);
    ev_t e;
    e.kind = kind;
    e.tick = tick;
    exp_q.push_back(e);
  endtask

  // returns 2.5 cycles after the n-th following TICK, i.e. well inside a TICK period
  task automatic wait_ticks(input int n);
    int target;
    target = tick_idx + n;
    while (tick_idx < target) @(negedge CLK);
    repeat (2) @(negedge CLK);
  endtask

  always @(negedge CLK) begin : monitor
    ev_t ev;
    if (press_p || rep_p) begin
      check("pulse_gap", int'(prev_pulse), 0);
      check("pulse_excl", int'(press_p && rep_p), 0);
      check("sb_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        check("pulse_kind", press_p ? K_PRESS : K_REP, ev.kind);
        check("pulse_tick", last_tick ? tick_idx : -1, ev.tick);
      end
    end
    prev_pulse = press_p || rep_p;
    if (press_nr) nr_press_cnt++;
    if (rep_nr) nr_rep_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, %0d pending events", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    int k, p, r, j;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_level", int'(level), 0);
    check("rst_press", int'(press_p), 0);
    check("rst_rep", int'(rep_p), 0);
    check("rst_toggle", int'(toggle), 0);
    check("rst_toggle_nr", int'(toggle_nr), 0);
    RESET = 1'b0;
    wait_ticks(1);

    // clean press, released before the first repeat would fire
    k = tick_idx;
    BTN_IN = 1'b1;
    push(K_PRESS, k + 4);
    wait_ticks(3);
    check("s1_level_pre", int'(level), 0);
    wait_ticks(1);
    check("s1_level", int'(level), 1);
    check("s1_toggle", int'(toggle), 1);
    wait_ticks(7);
    BTN_IN = 1'b0;
    wait_ticks(5);
    check("s1_release", int'(level), 0);

    // bounce: short burst, one-cycle dropout, then a real press
    BTN_IN = 1'b1;
    wait_ticks(2);
    check("s2_glitch_level", int'(level), 0);
    BTN_IN = 1'b0;
    @(negedge CLK);
    BTN_IN = 1'b1;
    k = tick_idx;
    p = k + 4;
    push(K_PRESS, p);
    push(K_REP, p + 8);
    push(K_REP, p + 11);
    push(K_REP, p + 14);
    push(K_REP, p + 17);
    push(K_REP, p + 20);
    wait_ticks(4);
    check("s2_level", int'(level), 1);
    check("s2_toggle", int'(toggle), 0);
    check("s2_toggle_nr", int'(toggle_nr), 0);
    wait_ticks(20);
    check("s3_level_nr", int'(level_nr), 1);
    BTN_IN = 1'b0;
    wait_ticks(3);
    check("s3_level_hold", int'(level), 1);
    wait_ticks(1);
    check("s3_release", int'(level), 0);
    check("s3_release_nr", int'(level_nr), 0);

    // release bounce while HELD restarts the repeat delay
    wait_ticks(1);
    k = tick_idx;
    BTN_IN = 1'b1;
    push(K_PRESS, k + 4);
    wait_ticks(4);
    wait_ticks(2);
    BTN_IN = 1'b0;
    wait_ticks(2);
    check("s4_level_bounce", int'(level), 1);
    BTN_IN = 1'b1;
    r = tick_idx;
    push(K_REP, r + 8);
    wait_ticks(8);
    BTN_IN = 1'b0;
    wait_ticks(5);
    check("s4_release", int'(level), 0);
    check("s4_toggle", int'(toggle), 1);

    // reset while repeating, button kept high through deassertion
    k = tick_idx;
    BTN_IN = 1'b1;
    push(K_PRESS, k + 4);
    push(K_REP, k + 12);
    wait_ticks(13);
    RESET = 1'b1;
    @(negedge CLK);
    check("s6_rst_level", int'(level), 0);
    check("s6_rst_toggle", int'(toggle), 0);
    check("s6_rst_level_nr", int'(level_nr), 0);
    check("s6_rst_toggle_nr", int'(toggle_nr), 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    j = tick_idx;
    push(K_PRESS, j + 4);
    wait_ticks(3);
    check("s6_level_pre", int'(level), 0);
    wait_ticks(1);
    check("s6_level", int'(level), 1);
    check("s6_toggle", int'(toggle), 1);
    check("s6_toggle_nr", int'(toggle_nr), 1);
    BTN_IN = 1'b0;
    wait_ticks(5);
    check("s6_release", int'(level), 0);

    check("sb_empty", exp_q.size(), 0);
    check("nr_press_cnt", nr_press_cnt, 5);
    check("nr_rep_cnt", nr_rep_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
